// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, EX redirect flushes and data-memory wait holds,
// plus a saturating count of PC-stall cycles.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 1023,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1addr,
  input  logic [4:0]       id_rs2addr,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rwaddr,
  input  logic             ex_writeRD,
  input  logic             ex_memRead,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_flush,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

  localparam logic [15:0] TIMEOUT_V = 16'(MEM_TIMEOUT);
  localparam logic [3:0]  FL_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state, state_n;
  logic [15:0] wait_cnt, wait_cnt_n;
  logic [3:0]  fl_cnt, fl_cnt_n;
  logic        redirect_pend, pend_n;
  logic        timeout_n;
  logic        lu;
  logic        run_eval, redir_eff, mem_blk;
  logic        pc_stall_c, if_id_stall_c, if_id_flush_c;
  logic        id_ex_bubble_c, id_ex_flush_c, pipe_hold_c;

  assign lu = ex_memRead && ex_writeRD && (ex_rwaddr != 5'd0) &&
              ((id_use_rs1 && (id_rs1addr == ex_rwaddr)) ||
               (id_use_rs2 && (id_rs2addr == ex_rwaddr)));

  always_comb begin
    state_n        = state;
    wait_cnt_n     = wait_cnt;
    fl_cnt_n       = fl_cnt;
    pend_n         = redirect_pend;
    timeout_n      = mem_timeout;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    id_ex_flush_c  = 1'b0;
    pipe_hold_c    = 1'b0;
    run_eval       = 1'b1;
    redir_eff      = ex_redirect;
    mem_blk        = mem_req && !mem_ready;

    case (state)
      MEM_WAIT: begin
        if (mem_ready || (wait_cnt == TIMEOUT_V)) begin
          // A timed-out access is abandoned, so the exit cycle never re-enters the wait.
          if (!mem_ready) timeout_n = 1'b1;
          redir_eff = ex_redirect || redirect_pend;
          pend_n    = 1'b0;
          mem_blk   = 1'b0;
          state_n   = RUN;
        end else begin
          run_eval      = 1'b0;
          pipe_hold_c   = 1'b1;
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          wait_cnt_n    = wait_cnt + 16'd1;
          if (ex_redirect) pend_n = 1'b1;
        end
      end
      REDIRECT: redir_eff = 1'b1;
      default: ;
    endcase

    if (run_eval) begin
      if (mem_blk) begin
        pipe_hold_c   = 1'b1;
        pc_stall_c    = 1'b1;
        if_id_stall_c = 1'b1;
        state_n       = MEM_WAIT;
        wait_cnt_n    = 16'd1;
        if (redir_eff) pend_n = 1'b1;
      end else if (redir_eff) begin
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        if (state == REDIRECT && !ex_redirect) begin
          if (fl_cnt == 4'd1) state_n = RUN;
          else                fl_cnt_n = fl_cnt - 4'd1;
        end else if (FLUSH_CYCLES > 1) begin
          state_n  = REDIRECT;
          fl_cnt_n = FL_RELOAD;
        end else begin
          state_n = RUN;
        end
      end else if (lu) begin
        pc_stall_c     = 1'b1;
        if_id_stall_c  = 1'b1;
        id_ex_bubble_c = 1'b1;
        state_n        = RUN;
      end else begin
        state_n = RUN;
      end
    end
  end

  assign pc_stall     = pc_stall_c     && !rst;
  assign if_id_stall  = if_id_stall_c  && !rst;
  assign if_id_flush  = if_id_flush_c  && !rst;
  assign id_ex_bubble = id_ex_bubble_c && !rst;
  assign id_ex_flush  = id_ex_flush_c  && !rst;
  assign pipe_hold    = pipe_hold_c    && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      wait_cnt      <= '0;
      fl_cnt        <= '0;
      redirect_pend <= 1'b0;
      mem_timeout   <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      state         <= state_n;
      wait_cnt      <= wait_cnt_n;
      fl_cnt        <= fl_cnt_n;
      redirect_pend <= pend_n;
      mem_timeout   <= timeout_n;
      if (pc_stall_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
